// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two memory requesters, the unified memory and the port arbiter.
// The master side drives requests and memory ready; the slave side is the arbiter itself.
interface mem_port_arbiter_if;
  logic Req0In;
  logic Req1In;
  logic MemReadyIn;
  logic SelectOut;
  logic MemReqOut;
  logic Gnt0Out;
  logic Gnt1Out;
  logic Done0Out;
  logic Done1Out;

  modport master (
    output Req0In, Req1In, MemReadyIn,
    input  SelectOut, MemReqOut, Gnt0Out, Gnt1Out, Done0Out, Done1Out
  );

  modport slave (
    input  Req0In, Req1In, MemReadyIn,
    output SelectOut, MemReqOut, Gnt0Out, Gnt1Out, Done0Out, Done1Out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fixed priority for the data port, starvation override for the fetch port,
// with back-to-back handover when the current owner's access completes.
module mem_port_arbiter #(
  parameter int WaitLimit = 4,
  parameter int CntWidth  = 3
) (
  input logic               ClockIn,
  input logic               ResetIn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Busy0 = 2'd1,
    Busy1 = 2'd2
  } stateT;

  localparam logic [CntWidth-1:0] WaitMax = CntWidth'(WaitLimit);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntZero = CntWidth'(0);

  stateT               state;
  stateT               nextState;
  logic [CntWidth-1:0] waitCnt;
  logic                starve;

  assign starve = (waitCnt >= WaitMax);

  function automatic stateT arbitrate(input logic r0, input logic r1, input logic st);
    stateT pick;
    if (r1 && st) begin
      pick = Busy1;
    end else if (r0) begin
      pick = Busy0;
    end else if (r1) begin
      pick = Busy1;
    end else begin
      pick = Idle;
    end
    return pick;
  endfunction

  // Next owner; a finishing port is excluded because its request is still high in its Done cycle.
  always_comb begin
    nextState = state;
    case (state)
      Idle: begin
        nextState = arbitrate(bus.Req0In, bus.Req1In, starve);
      end
      Busy0: begin
        if (bus.MemReadyIn) begin
          nextState = arbitrate(1'b0, bus.Req1In, starve);
        end else begin
          nextState = Busy0;
        end
      end
      Busy1: begin
        if (bus.MemReadyIn) begin
          nextState = arbitrate(bus.Req0In, 1'b0, starve);
        end else begin
          nextState = Busy1;
        end
      end
      default: begin
        nextState = Idle;
      end
    endcase
  end

  // State, fetch-port wait counter and the state-decoded registered outputs.
  always_ff @(posedge ClockIn or posedge ResetIn) begin
    if (ResetIn) begin
      state         <= Idle;
      waitCnt       <= CntZero;
      bus.SelectOut <= 1'b0;
      bus.MemReqOut <= 1'b0;
      bus.Gnt0Out   <= 1'b0;
      bus.Gnt1Out   <= 1'b0;
    end else begin
      state         <= nextState;
      bus.SelectOut <= (nextState == Busy0);
      bus.MemReqOut <= (nextState != Idle);
      bus.Gnt0Out   <= (nextState == Busy0);
      bus.Gnt1Out   <= (nextState == Busy1);
      if (!bus.Req1In || ((nextState == Busy1) && (state != Busy1))) begin
        waitCnt <= CntZero;
      end else if ((state != Busy1) && (waitCnt < WaitMax)) begin
        waitCnt <= waitCnt + CntOne;
      end else begin
        waitCnt <= waitCnt;
      end
    end
  end

  // Done follows the memory's ready within the same cycle, only for the current owner.
  assign bus.Done0Out = bus.Gnt0Out & bus.MemReadyIn;
  assign bus.Done1Out = bus.Gnt1Out & bus.MemReadyIn;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a long random run,
// all compared every cycle against an owner/queue-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.WaitLimit(LIMIT), .CntWidth(3)) dut (
    .ClockIn(clk),
    .ResetIn(rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: owner is -1 (none), 0 or 1; waited counts cycles port 1 has been kept waiting.
  int   owner  = -1;
  int   waited = 0;
  int   mNext;
  logic expD0  = 1'b0;
  logic expD1  = 1'b0;

  logic randPhase = 1'b0;
  int   rise0 = 0, rise1 = 0, done0Cnt = 0, done1Cnt = 0;
  int   waitAcc = 0;
  logic prevG0 = 1'b0, prevG1 = 1'b0;
  int   g1Seen = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1, input int cnt);
    if (r1 && cnt >= LIMIT) return 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Compare process: every falling edge, check DUT outputs against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        owner  = -1;
        waited = 0;
      end
      expD0 = !rst && (owner == 0) && bus.MemReadyIn;
      expD1 = !rst && (owner == 1) && bus.MemReadyIn;
      check("select", bus.SelectOut, owner == 0);
      check("memreq", bus.MemReqOut, owner != -1);
      check("gnt0",   bus.Gnt0Out,   owner == 0);
      check("gnt1",   bus.Gnt1Out,   owner == 1);
      check("done0",  bus.Done0Out,  expD0);
      check("done1",  bus.Done1Out,  expD1);
      check("gnt_exclusive", bus.Gnt0Out & bus.Gnt1Out, 1'b0);
      check("done_needs_memreq", (bus.Done0Out | bus.Done1Out) & ~bus.MemReqOut, 1'b0);

      if (bus.Gnt0Out && !prevG0 && bus.Req1In) waitAcc++;
      if (!bus.Req1In) waitAcc = 0;
      if (bus.Gnt1Out && !prevG1) begin
        check("port1_wait_bound", waitAcc <= LIMIT + 1, 1'b1);
        waitAcc = 0;
      end
      prevG0 = bus.Gnt0Out;
      prevG1 = bus.Gnt1Out;
      if (randPhase) begin
        done0Cnt += int'(bus.Done0Out);
        done1Cnt += int'(bus.Done1Out);
      end

      if (!rst) begin
        if (owner == -1) mNext = pick(bus.Req0In, bus.Req1In, waited);
        else if (!bus.MemReadyIn) mNext = owner;
        else if (owner == 0) mNext = pick(1'b0, bus.Req1In, waited);
        else mNext = pick(bus.Req0In, 1'b0, waited);
        if (!bus.Req1In || (mNext == 1 && owner != 1)) waited = 0;
        else if (owner != 1 && waited < LIMIT) waited = waited + 1;
        owner = mNext;
      end
    end
  end

  task automatic drive(input logic r0, input logic r1, input logic rdy);
    @(posedge clk);
    #1;
    bus.Req0In     = r0;
    bus.Req1In     = r1;
    bus.MemReadyIn = rdy;
  endtask

  // Stimulus: directed scenarios with literal expectations, then randomized traffic.
  initial begin
    bus.Req0In     = 1'b0;
    bus.Req1In     = 1'b0;
    bus.MemReadyIn = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_memreq", bus.MemReqOut, 1'b0);
    check("reset_select", bus.SelectOut, 1'b0);

    // Single data-port access, ready on 3rd busy cycle.
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); check("t1_latency", bus.MemReqOut, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); check("t1_memreq", bus.MemReqOut, 1'b1);
    check("t1_select", bus.SelectOut, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk); check("t1_done0", bus.Done0Out, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk); check("t1_idle", bus.MemReqOut, 1'b0);

    // Both request together, latency 2, handover without a bubble.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk); check("t2_busy0_select", bus.SelectOut, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk); check("t2_done0", bus.Done0Out, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk); check("t2_handover_select", bus.SelectOut, 1'b0);
    check("t2_handover_memreq", bus.MemReqOut, 1'b1);
    check("t2_handover_gnt1", bus.Gnt1Out, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk); check("t2_done1", bus.Done1Out, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Sustained contention: port 1 must keep getting turns.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk); g1Seen += int'(bus.Gnt1Out);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
    end
    check("t3_port1_granted", g1Seen != 0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a data access.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); check("t4_busy0", bus.Gnt0Out, 1'b1);
    @(posedge clk);
    #2;
    bus.MemReadyIn = 1'b1;
    rst = 1'b1;
    #1;
    check("t4_async_memreq", bus.MemReqOut, 1'b0);
    check("t4_async_gnt0",   bus.Gnt0Out,   1'b0);
    check("t4_async_done0",  bus.Done0Out,  1'b0);
    bus.Req0In     = 1'b0;
    bus.MemReadyIn = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk); check("t4_idle_after", bus.MemReqOut, 1'b0);

    // Memory ready toggling with nothing requested.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, i[0]);
      @(negedge clk);
      check("t5_no_done", bus.Done0Out | bus.Done1Out, 1'b0);
    end

    // Random traffic under the hold-until-Done protocol.
    drive(1'b0, 1'b0, 1'b0);
    randPhase = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (bus.Req0In && expD0) bus.Req0In = 1'b0;
      else if (!bus.Req0In && $urandom_range(3) == 0) begin bus.Req0In = 1'b1; rise0++; end
      if (bus.Req1In && expD1) bus.Req1In = 1'b0;
      else if (!bus.Req1In && $urandom_range(3) == 0) begin bus.Req1In = 1'b1; rise1++; end
      bus.MemReadyIn = ($urandom_range(2) == 0);
    end
    for (int i = 0; i < 40 && (bus.Req0In || bus.Req1In); i++) begin
      @(posedge clk);
      #1;
      if (bus.Req0In && expD0) bus.Req0In = 1'b0;
      if (bus.Req1In && expD1) bus.Req1In = 1'b0;
      bus.MemReadyIn = 1'b1;
    end
    check("t6_drained", bus.Req0In | bus.Req1In, 1'b0);
    @(negedge clk);
    randPhase = 1'b0;
    check("t6_done0_per_request", rise0 == done0Cnt, 1'b1);
    check("t6_done1_per_request", rise1 == done1Cnt, 1'b1);
    if (rise0 != done0Cnt || rise1 != done1Cnt)
      $display("counts: req0=%0d done0=%0d req1=%0d done1=%0d", rise0, done0Cnt, rise1, done1Cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
